// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter among NUM_REQ
// byte producers. A winner is latched in IDLE, tx_start/req_ready pulse for
// one cycle, then the arbiter follows tx_busy high and back low before the
// next grant.
// Optional feature macro: UART_TX_ARB_TIMEOUT_EN -- bounds the wait for
// tx_busy to rise after tx_start and raises a sticky err_timeout on expiry.
module uart_tx_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [NUM_REQ-1:0]                          req_valid,
    input  logic [8*NUM_REQ-1:0]                        req_data,
    output logic [NUM_REQ-1:0]                          req_ready,
    output logic                                        tx_start,
    output logic [7:0]                                  tx_data,
    input  logic                                        tx_busy,
    output logic [(NUM_REQ > 1 ? $clog2(NUM_REQ) : 1)-1:0] grant_id,
    output logic                                        arb_busy,
    output logic                                        err_timeout
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_ACK  = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t               state_reg, state_next;
    logic [IW-1:0]        rr_ptr_reg, rr_ptr_next;
    logic [IW-1:0]        grant_id_reg, grant_id_next;
    logic [7:0]           tx_data_reg, tx_data_next;
    logic                 tx_start_reg, tx_start_next;
    logic [NUM_REQ-1:0]   req_ready_reg, req_ready_next;

    // ------------------------------------------------------------------
    // Round-robin winner selection.
    // Two lowest-index-first searches: one restricted to requesters above
    // the last grant, one over everything. If anybody above the pointer is
    // valid it wins, otherwise the search has wrapped to the lowest valid.
    // Chains run from the top index down so element 0 holds the result.
    // ------------------------------------------------------------------
    logic [NUM_REQ-1:0]   hi_valid;
    logic [IW-1:0]        hi_idx  [NUM_REQ+1];
    logic [7:0]           hi_byte [NUM_REQ+1];
    logic [IW-1:0]        lo_idx  [NUM_REQ+1];
    logic [7:0]           lo_byte [NUM_REQ+1];
    logic                 win_found;
    logic                 any_hi;
    logic [IW-1:0]        win_idx;
    logic [7:0]           win_byte;
    logic [NUM_REQ-1:0]   win_onehot;

    assign hi_idx[NUM_REQ]  = '0;
    assign hi_byte[NUM_REQ] = '0;
    assign lo_idx[NUM_REQ]  = '0;
    assign lo_byte[NUM_REQ] = '0;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_pick
        assign hi_valid[gi] = req_valid[gi] && (IW'(gi) > rr_ptr_reg);
        assign hi_idx[gi]   = hi_valid[gi]  ? IW'(gi) : hi_idx[gi+1];
        assign hi_byte[gi]  = hi_valid[gi]  ? req_data[8*gi +: 8] : hi_byte[gi+1];
        assign lo_idx[gi]   = req_valid[gi] ? IW'(gi) : lo_idx[gi+1];
        assign lo_byte[gi]  = req_valid[gi] ? req_data[8*gi +: 8] : lo_byte[gi+1];
        assign win_onehot[gi] = (win_idx == IW'(gi));
    end

    assign win_found = |req_valid;
    assign any_hi    = |hi_valid;
    assign win_idx   = any_hi ? hi_idx[0]  : lo_idx[0];
    assign win_byte  = any_hi ? hi_byte[0] : lo_byte[0];

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
    logic [CW-1:0] ack_cnt_reg, ack_cnt_next;
    logic          err_reg, err_next;
`endif

    // State and output registers; reset aborts any transfer immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            rr_ptr_reg    <= IW'(NUM_REQ - 1);
            grant_id_reg  <= '0;
            tx_data_reg   <= '0;
            tx_start_reg  <= 1'b0;
            req_ready_reg <= '0;
        end else begin
            state_reg     <= state_next;
            rr_ptr_reg    <= rr_ptr_next;
            grant_id_reg  <= grant_id_next;
            tx_data_reg   <= tx_data_next;
            tx_start_reg  <= tx_start_next;
            req_ready_reg <= req_ready_next;
        end
    end

`ifdef UART_TX_ARB_TIMEOUT_EN
    // Acknowledge-timeout counter and sticky error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_cnt_reg <= '0;
            err_reg     <= 1'b0;
        end else begin
            ack_cnt_reg <= ack_cnt_next;
            err_reg     <= err_next;
        end
    end
`endif

    // Next-state and registered-output logic for the grant sequencer.
    always_comb begin
        state_next     = state_reg;
        rr_ptr_next    = rr_ptr_reg;
        grant_id_next  = grant_id_reg;
        tx_data_next   = tx_data_reg;
        tx_start_next  = 1'b0;
        req_ready_next = '0;
`ifdef UART_TX_ARB_TIMEOUT_EN
        ack_cnt_next   = ack_cnt_reg;
        err_next       = err_reg;
`endif
        case (state_reg)
            IDLE: begin
                // Only grant into an idle transmitter so the byte is not lost.
                if (!tx_busy && win_found) begin
                    tx_data_next   = win_byte;
                    grant_id_next  = win_idx;
                    rr_ptr_next    = win_idx;
                    tx_start_next  = 1'b1;
                    req_ready_next = win_onehot;
                    state_next     = START;
                end
            end
            START: begin
`ifdef UART_TX_ARB_TIMEOUT_EN
                ack_cnt_next = '0;
`endif
                state_next = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (tx_busy) begin
                    state_next = WAIT_DONE;
                end
`ifdef UART_TX_ARB_TIMEOUT_EN
                else if (ack_cnt_reg == CW'(ACK_TIMEOUT - 1)) begin
                    err_next   = 1'b1;
                    state_next = IDLE;
                end else begin
                    ack_cnt_next = ack_cnt_reg + 1'b1;
                end
`endif
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign tx_start  = tx_start_reg;
    assign req_ready = req_ready_reg;
    assign tx_data   = tx_data_reg;
    assign grant_id  = grant_id_reg;
    assign arb_busy  = (state_reg != IDLE);

`ifdef UART_TX_ARB_TIMEOUT_EN
    assign err_timeout = err_reg;
`else
    assign err_timeout = 1'b0;
`endif

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one dynamic-baud UART transmitter among NUM_REQ byte-producing requesters (loopback echo path, status reporter, debug console, ...).
- Uses a round-robin grant.
- Drives the transmitter's tx_start/tx_data and sequences each byte by watching its tx_busy.
- Sits between the requesters and the transmitter instance in the UART top level.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ACK_TIMEOUT, 16, cycles to wait for tx_busy to rise after tx_start (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- req_valid  in  NUM_REQ  per-requester byte-available; held until that requester's req_ready pulses
- req_data  in  8*NUM_REQ  requester i's byte on bits [8i+7:8i]; stable while req_valid[i]
- req_ready  out  NUM_REQ  one-cycle accept pulse; at most one bit high
- tx_start  out  1  one-cycle start pulse to transmitter
- tx_data  out  8  byte to transmitter; held stable from tx_start until return to IDLE
- tx_busy  in  1  transmitter busy
- grant_id  out  clog2(NUM_REQ)  index of last granted requester
- arb_busy  out  1  high in any state other than IDLE
- err_timeout  out  1  sticky timeout flag (see Optional Feature)

Interface: reset rst, asynchronous, active-high; clock clk.

Behaviour:
- Reset values: req_ready=0, tx_start=0, tx_data=0, grant_id=0, arb_busy=0, err_timeout=0, state=IDLE, rr pointer=NUM_REQ-1 (requester 0 wins first).
- States: IDLE, START, WAIT_ACK, WAIT_DONE.
- IDLE: if tx_busy==0 and |req_valid, pick winner w = first valid index searching from rr_ptr+1 upward with wrap modulo NUM_REQ. At the clock edge: tx_data<=req_data[w], grant_id<=w, rr_ptr<=w, tx_start<=1, req_ready[w]<=1, go to START.
- IDLE with tx_busy==1 (transmitter still finishing or externally driven): no grant. Wait.
- START (one cycle): tx_start and req_ready are high this cycle only. Next edge clears both and goes to WAIT_ACK.
- WAIT_ACK: tx_busy==1 goes to WAIT_DONE.
- WAIT_DONE: tx_busy==0 goes to IDLE.
- Latency: a valid seen in IDLE at edge T gives tx_start high in cycle T+1. Next grant is no earlier than 1 cycle after tx_busy falls.
- Requester protocol: after req_ready[i] pulses, requester i may drop valid or present the next byte. A byte is never sent twice; a valid is never dropped by the arbiter.
- Fairness: with all requesters continuously valid, grants cycle 0,1,2,3,0,...
- A new valid arriving mid-transfer is held pending; it does not affect tx_data.
- rst asserted mid-transfer aborts immediately. Outputs take reset values; the in-flight byte is already accepted and is not re-requested.
- NUM_REQ==1 degenerates to a pass-through sequencer with grant_id=0.

Optional Feature:
- Macro UART_TX_ARB_TIMEOUT_EN.
- Defined: a counter runs in WAIT_ACK. If tx_busy does not rise within ACK_TIMEOUT cycles of entering WAIT_ACK, set err_timeout=1 (sticky until rst) and return to IDLE. Arbitration continues.
- Undefined: WAIT_ACK waits indefinitely; err_timeout is tied 0 and there is no counter logic.

Test Plan:
- Single request: req_valid=4'b0010, req_data[15:8]=8'hA5, idle transmitter model → tx_start one cycle with tx_data=8'hA5, req_ready=4'b0010 in the same cycle, grant_id=1, no second tx_start until valid is reasserted.
- Round-robin: all four valid continuously with bytes 8'h10..8'h13 → transmitted order 10,11,12,13,10. Each tx_start occurs only after the previous tx_busy fall.
- Transmitter busy at start: tx_busy=1 while req_valid[0]=1 → no tx_start until 1 cycle after tx_busy=0.
- Late arrival: requester 2 valid while requester 0's byte is in WAIT_DONE → tx_data stays at requester 0's byte; requester 2 is granted next.
- Reset mid-transfer: rst pulsed in WAIT_DONE → all outputs 0, state IDLE; the next grant goes to requester 0.
- With UART_TX_ARB_TIMEOUT_EN and ACK_TIMEOUT=16: tx_busy held 0 after tx_start → err_timeout=1 after 16 cycles in WAIT_ACK, arb_busy=0, the next pending request is granted.
